// File: rtl/bpsk_demod_if.sv
// Sample/carrier input and recovered-bit output bundle for bpsk_demod.
// Optional soft_sig output is present when BPSK_DEMOD_SOFT_EN is defined.
interface bpsk_demod_if #(
  parameter int DATA_W = 16
);
  logic                     en_p;
  logic                     sym_sync;
  logic signed [DATA_W-1:0] bpsk_sig;
  logic signed [DATA_W-1:0] carrier_sig;
  logic                     base_sig;
  logic                     bit_vld;
  logic                     locked;
  logic                     sync_err;
`ifdef BPSK_DEMOD_SOFT_EN
  logic signed [DATA_W-1:0] soft_sig;

  modport master (
    output en_p, sym_sync, bpsk_sig, carrier_sig,
    input  base_sig, bit_vld, locked, sync_err, soft_sig
  );

  modport slave (
    input  en_p, sym_sync, bpsk_sig, carrier_sig,
    output base_sig, bit_vld, locked, sync_err, soft_sig
  );
`else
  modport master (
    output en_p, sym_sync, bpsk_sig, carrier_sig,
    input  base_sig, bit_vld, locked, sync_err
  );

  modport slave (
    input  en_p, sym_sync, bpsk_sig, carrier_sig,
    output base_sig, bit_vld, locked, sync_err
  );
`endif
endinterface

// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: multiply by local carrier, integrate over a symbol, slice on sign.
// Define BPSK_DEMOD_SOFT_EN to add the soft_sig correlation-magnitude output.
//
// state | meaning
// IDLE  | waiting for en_p with sym_sync to establish symbol timing
// RUN   | locked; every enabled cycle captures one sample
module bpsk_demod #(
  parameter int DATA_W = 16,
  parameter int SPB    = 16
) (
  input  logic         clk_sig,
  input  logic         rst_n,
  bpsk_demod_if.slave  bus
);

  localparam int ACC_W  = 2*DATA_W + $clog2(SPB);
  localparam int PROD_W = 2*DATA_W;
  localparam int CNT_W  = $clog2(SPB);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_d;

  logic signed [PROD_W-1:0] prod_r;
  logic                     first_r;
  logic                     prod_vld;
  logic                     serr_r;
  logic        [CNT_W-1:0]  samp_idx;
  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;
  logic                     base_r;
  logic                     bit_vld_r;
  logic                     sync_err_r;

  logic                     capture;
  logic                     first_s1;
  logic                     off_sync;
  logic signed [PROD_W-1:0] prod_next;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic                     complete;

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!bus.en_p)                       state_d = IDLE;
    else if (state == IDLE && bus.sym_sync) state_d = RUN;
  end

  // samp_idx is the expected index of the sample arriving at stage 1
  assign capture  = bus.en_p && (state == RUN || bus.sym_sync);
  assign first_s1 = (state == IDLE) || bus.sym_sync || (samp_idx == '0);
  assign off_sync = (state == RUN) && bus.sym_sync && (samp_idx != '0);

  assign prod_next = $signed({{DATA_W{bus.bpsk_sig[DATA_W-1]}}, bus.bpsk_sig}) *
                     $signed({{DATA_W{bus.carrier_sig[DATA_W-1]}}, bus.carrier_sig});

  assign prod_ext = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
  assign sum      = first_r ? prod_ext : acc + prod_ext;
  assign complete = !first_r && (cnt == CNT_W'(SPB-1));

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      prod_r     <= '0;
      first_r    <= 1'b0;
      prod_vld   <= 1'b0;
      serr_r     <= 1'b0;
      samp_idx   <= '0;
      acc        <= '0;
      cnt        <= '0;
      base_r     <= 1'b0;
      bit_vld_r  <= 1'b0;
      sync_err_r <= 1'b0;
    end else if (!bus.en_p) begin
      prod_vld   <= 1'b0;
      serr_r     <= 1'b0;
      samp_idx   <= '0;
      acc        <= '0;
      cnt        <= '0;
      bit_vld_r  <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      prod_vld <= capture;
      serr_r   <= capture && off_sync;
      if (capture) begin
        prod_r  <= prod_next;
        first_r <= first_s1;
        if (first_s1)                           samp_idx <= CNT_W'(1);
        else if (samp_idx == CNT_W'(SPB-1))     samp_idx <= '0;
        else                                    samp_idx <= samp_idx + CNT_W'(1);
      end

      bit_vld_r  <= 1'b0;
      sync_err_r <= 1'b0;
      if (prod_vld) begin
        acc        <= sum;
        sync_err_r <= serr_r;
        if (complete) begin
          cnt       <= '0;
          bit_vld_r <= 1'b1;
          base_r    <= ~sum[ACC_W-1];
        end else begin
          cnt <= first_r ? CNT_W'(1) : cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef BPSK_DEMOD_SOFT_EN
  logic signed [DATA_W-1:0] soft_r;

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n)
      soft_r <= '0;
    else if (bus.en_p && prod_vld && complete)
      soft_r <= sum[ACC_W-1 -: DATA_W];
  end

  assign bus.soft_sig = soft_r;
`endif

  assign bus.base_sig = base_r;
  assign bus.bit_vld  = bit_vld_r;
  assign bus.locked   = (state == RUN);
  assign bus.sync_err = sync_err_r;

endmodule

// File: tb/tb_bpsk_demod.sv
// Self-checking bench for bpsk_demod: directed scenarios plus randomized traffic,
// compared every cycle against a symbol-level correlation model.
module tb_bpsk_demod;

  localparam int DATA_W = 16;
  localparam int SPB    = 16;
  localparam int SHIFT  = DATA_W + $clog2(SPB);

  logic clk_sig = 1'b0;
  logic rst_n   = 1'b0;

  always #5 clk_sig = ~clk_sig;

  bpsk_demod_if #(.DATA_W(DATA_W)) bus ();

  bpsk_demod #(.DATA_W(DATA_W), .SPB(SPB)) dut (
    .clk_sig (clk_sig),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: outputs after each edge; a decided bit appears one edge after its last sample enters
  bit          m_run;
  int          m_idx;
  longint      m_sum;
  bit          p_bit, p_val, p_serr;
  logic [15:0] p_soft;
  bit          e_bit_vld, e_base, e_locked, e_serr;
  logic [15:0] e_soft;

  always @(posedge clk_sig or negedge rst_n) begin
    longint prod;
    bit     first;
    if (!rst_n) begin
      m_run = 0; m_idx = 0; m_sum = 0;
      p_bit = 0; p_val = 0; p_serr = 0; p_soft = '0;
      e_bit_vld = 0; e_base = 0; e_locked = 0; e_serr = 0; e_soft = '0;
    end else if (!bus.en_p) begin
      m_run = 0; m_idx = 0; m_sum = 0;
      p_bit = 0; p_serr = 0;
      e_bit_vld = 0; e_serr = 0; e_locked = 0;
    end else begin
      e_bit_vld = p_bit;
      e_serr    = p_serr;
      if (p_bit) begin
        e_base = p_val;
        e_soft = p_soft;
      end
      p_bit  = 0;
      p_serr = 0;
      if (m_run || bus.sym_sync) begin
        prod  = longint'($signed(bus.bpsk_sig)) * longint'($signed(bus.carrier_sig));
        first = !m_run || bus.sym_sync || (m_idx == 0);
        if (m_run && bus.sym_sync && m_idx != 0) p_serr = 1;
        if (first) begin
          m_sum = prod;
          m_idx = 1;
        end else begin
          m_sum = m_sum + prod;
          m_idx = m_idx + 1;
        end
        if (m_idx == SPB) begin
          p_bit  = 1;
          p_val  = (m_sum >= 0);
          p_soft = 16'(m_sum >>> SHIFT);
          m_idx  = 0;
        end
        m_run = 1;
      end
      e_locked = m_run;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic do_checks();
    check_val("bit_vld",  32'(bus.bit_vld),  32'(e_bit_vld));
    check_val("base_sig", 32'(bus.base_sig), 32'(e_base));
    check_val("locked",   32'(bus.locked),   32'(e_locked));
    check_val("sync_err", 32'(bus.sync_err), 32'(e_serr));
`ifdef BPSK_DEMOD_SOFT_EN
    check_val("soft_sig", 32'(bus.soft_sig), 32'(e_soft));
`endif
  endtask

  task automatic cyc(input bit en, input bit sync, input int b, input int c);
    @(negedge clk_sig);
    do_checks();
    bus.en_p        = en;
    bus.sym_sync    = sync;
    bus.bpsk_sig    = 16'(b);
    bus.carrier_sig = 16'(c);
  endtask

  task automatic sym(input int b, input int c, input int n, input bit sync_first);
    for (int i = 0; i < n; i++) cyc(1'b1, sync_first && (i == 0), b, c);
  endtask

  initial begin
    int c_r, b_r;
    bit tx;
    bus.en_p = 0; bus.sym_sync = 0; bus.bpsk_sig = '0; bus.carrier_sig = '0;

    repeat (3) cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) cyc(0, 0, 0, 0);

    // matched symbol, then antipodal pair back to back
    sym(1000, 1000, SPB, 1);
    sym(-1000, 1000, SPB, 0);
    sym(1000, 1000, SPB, 0);
    repeat (3) cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // zero correlation resolves to 1
    for (int i = 0; i < SPB; i++) cyc(1, i == 0, (i % 2 == 0) ? 500 : -500, 500);
    repeat (2) cyc(0, 0, 0, 0);

    // mid-symbol re-sync, then a full symbol from the new boundary
    sym(-800, 900, 7, 1);
    sym(-800, 900, SPB, 1);
    sym(700, 700, 4, 0);
    repeat (2) cyc(0, 0, 0, 0);

    // enable dropped mid-symbol; samples ignored until next sym_sync
    sym(1200, -1200, 10, 1);
    repeat (3) cyc(0, 0, 0, 0);
    sym(1200, 1200, 5, 0);
    sym(1200, 1200, SPB, 1);
    repeat (2) cyc(1, 0, 0, 0);

    // asynchronous reset between edges mid-symbol
    sym(-3000, 2000, 5, 1);
    @(negedge clk_sig);
    do_checks();
    #2 rst_n = 1'b0;
    #1 do_checks();
    cyc(1, 0, 1000, 1000);
    rst_n = 1'b1;
    sym(1000, 1000, 20, 0);
    sym(-1000, 1000, SPB, 1);
    repeat (3) cyc(1, 0, 0, 0);

    // randomized traffic with occasional enable drops and stray syncs
    tx = 0;
    for (int k = 0; k < 900; k++) begin
      if (k % SPB == 0) tx = bit'($urandom_range(0, 1));
      c_r = int'($signed(16'($urandom)));
      if ($urandom_range(0, 3) == 0) b_r = int'($signed(16'($urandom)));
      else                           b_r = tx ? c_r : -c_r;
      cyc($urandom_range(0, 99) < 96, $urandom_range(0, 99) < 5, b_r, c_r);
    end
    repeat (4) cyc(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
